// File: rtl/path_stream_sched.sv
// Ping-pong path buffer between the path generator and the pricer: captures
// DAY-sample paths, streams them one sample per cycle with replay, counts N acks.
module path_stream_sched #(
    parameter int DAY = 8,
    parameter int N   = 256,
    parameter int W   = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               gen_valid,
    input  logic [W-1:0]       gen_path,
    output logic               gen_hold,
    output logic               out_valid,
    output logic [W-1:0]       out_path,
    output logic               out_last,
    input  logic               resend,
    input  logic               prc_ack,
    output logic [$clog2(N):0] path_cnt,
    output logic               busy,
    output logic               done
);
    localparam int IW = $clog2(DAY);
    localparam int CW = $clog2(N) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DAY - 1);
    localparam logic [CW-1:0] N_CNT    = CW'(N);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_SEND = 2'd1;
    localparam logic [1:0] R_WAIT = 2'd2;
    localparam logic [1:0] R_DONE = 2'd3;

    logic [1:0][DAY-1:0][W-1:0] mem;
    logic [1:0]    full;
    logic          wr_bank, rd_bank;
    logic [IW-1:0] wr_idx, rd_idx, rd_nxt;
    logic [CW-1:0] cnt_nxt;
    logic [1:0]    state;
    logic          wr_en, go_send;

    assign gen_hold = !busy || full[wr_bank];
    assign wr_en    = gen_valid && !gen_hold;
    assign rd_nxt   = rd_idx + 1'b1;
    assign cnt_nxt  = path_cnt + 1'b1;
    // Replay beats everything else; otherwise an idle reader picks up a full bank.
    assign go_send  = (resend && (state == R_SEND || state == R_WAIT)) ||
                      (state == R_IDLE && busy && full[rd_bank]);

    // Sample storage needs no reset: the full flags say what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_bank][wr_idx] <= gen_path;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            path_cnt  <= '0;
            state     <= R_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_path  <= '0;
            out_last  <= 1'b0;
        end else if (start) begin
            full      <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            path_cnt  <= '0;
            state     <= R_IDLE;
            busy      <= 1'b1;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_path  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_idx <= wr_idx + 1'b1;
                if (wr_idx == LAST_IDX) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end

            if (go_send) begin
                state     <= R_SEND;
                rd_idx    <= '0;
                out_valid <= 1'b1;
                out_path  <= mem[rd_bank][0];
                out_last  <= 1'b0;
            end else begin
                case (state)
                    R_SEND: begin
                        if (rd_idx == LAST_IDX) begin
                            state     <= R_WAIT;
                            out_valid <= 1'b0;
                            out_path  <= '0;
                            out_last  <= 1'b0;
                        end else begin
                            rd_idx   <= rd_nxt;
                            out_path <= mem[rd_bank][rd_nxt];
                            out_last <= (rd_nxt == LAST_IDX);
                        end
                    end
                    R_WAIT: begin
                        // The writer is held off this bank while full, so this clear never races a fill.
                        if (prc_ack) begin
                            full[rd_bank] <= 1'b0;
                            rd_bank       <= ~rd_bank;
                            path_cnt      <= cnt_nxt;
                            if (cnt_nxt == N_CNT) begin
                                state <= R_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= R_IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_path_stream_sched.sv
// Bench for path_stream_sched: queue-based path model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_path_stream_sched;
    localparam int DAY = 8;
    localparam int N   = 4;
    localparam int W   = 12;
    typedef logic [DAY*W-1:0] path_t;

    logic         clk, rst_n, start, gen_valid, resend, prc_ack;
    logic [W-1:0] gen_path;
    logic         gen_hold, out_valid, out_last, busy, done;
    logic [W-1:0] out_path;
    logic [$clog2(N):0] path_cnt;

    path_stream_sched #(.DAY(DAY), .N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .gen_valid(gen_valid), .gen_path(gen_path), .gen_hold(gen_hold),
        .out_valid(out_valid), .out_path(out_path), .out_last(out_last),
        .resend(resend), .prc_ack(prc_ack),
        .path_cnt(path_cnt), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: completed paths wait in a queue (front = the one being served);
    // m_pos is the stream position: -1 none, 0..DAY-1 sending, DAY awaiting ack.
    path_t q[$];
    path_t m_part = '0;
    int    m_part_n = 0;
    int    m_pos = -1;
    int    m_cnt = 0;
    bit    m_busy = 0;
    bit    m_done = 0;
    int    m_nfull;
    bit    m_acc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || start) begin
            q.delete();
            m_part_n = 0;
            m_pos    = -1;
            m_cnt    = 0;
            m_busy   = rst_n && start;
            m_done   = 0;
        end else begin
            m_nfull = q.size();
            m_acc   = gen_valid && m_busy && (m_nfull < 2);
            if (m_pos >= 0 && resend) m_pos = 0;
            else if (m_pos >= 0 && m_pos < DAY) m_pos++;
            else if (m_pos == DAY) begin
                if (prc_ack) begin
                    void'(q.pop_front());
                    m_cnt++;
                    m_pos = -1;
                    if (m_cnt == N) begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end
            end else if (m_busy && m_nfull > 0) m_pos = 0;
            if (m_acc) begin
                m_part[m_part_n*W +: W] = gen_path;
                m_part_n++;
                if (m_part_n == DAY) begin
                    q.push_back(m_part);
                    m_part_n = 0;
                end
            end
        end
    end

    path_t cur;
    bit    e_valid;
    always @(negedge clk) begin
        if (chk_on) begin
            e_valid = (m_pos >= 0 && m_pos < DAY);
            cur     = (q.size() > 0) ? q[0] : '0;
            chk("m_gen_hold", gen_hold, !m_busy || q.size() == 2);
            chk("m_out_valid", out_valid, e_valid);
            chk("m_out_last", out_last, m_pos == DAY - 1);
            if (e_valid) chk("m_out_path", out_path, cur[m_pos*W +: W]);
            chk("m_path_cnt", path_cnt, m_cnt);
            chk("m_busy", busy, m_busy);
            chk("m_done", done, m_done);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    bit was_last;
    initial begin
        rst_n = 0; start = 0; gen_valid = 0; gen_path = '0; resend = 0; prc_ack = 0;
        repeat (3) step();
        rst_n = 1;
        chk_on = 1;
        chk("rst_gen_hold", gen_hold, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_path_cnt", path_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // Single path 0x001..0x008, first sample two cycles after the last write.
        start = 1; step(); start = 0;
        chk("start_busy", busy, 1);
        chk("start_gen_hold", gen_hold, 0);
        for (int i = 1; i <= DAY; i++) begin
            gen_valid = 1; gen_path = W'(i); step();
        end
        gen_valid = 0;
        chk("lat_no_valid_yet", out_valid, 0);
        step();
        for (int i = 1; i <= DAY; i++) begin
            chk("p1_valid", out_valid, 1);
            chk("p1_data", out_path, i);
            chk("p1_last", out_last, i == DAY);
            step();
        end
        chk("p1_ended", out_valid, 0);
        prc_ack = 1; step(); prc_ack = 0;
        chk("p1_cnt", path_cnt, 1);

        // Three paths back-to-back, no ack: third is dropped under hold.
        for (int k = 0; k < 3*DAY; k++) begin
            if (k == 2*DAY) chk("p3_held", gen_hold, 1);
            gen_valid = 1; gen_path = W'(12'h100 + k); step();
        end
        gen_valid = 0;
        chk("p3_still_held", gen_hold, 1);
        prc_ack = 1; step(); prc_ack = 0;
        chk("ack_hold_drop", gen_hold, 0);
        chk("ack_cnt", path_cnt, 2);
        step();

        // Resend during the 4th streamed sample.
        for (int i = 0; i < 4; i++) begin
            chk("p2_data", out_path, 12'h108 + i);
            if (i == 3) resend = 1;
            step();
        end
        resend = 0;
        for (int i = 0; i < DAY; i++) begin
            chk("replay_valid", out_valid, 1);
            chk("replay_data", out_path, 12'h108 + i);
            chk("replay_last", out_last, i == DAY - 1);
            step();
        end

        // Resend and ack together while waiting: replay wins.
        resend = 1; prc_ack = 1; step(); resend = 0; prc_ack = 0;
        chk("rs_ack_valid", out_valid, 1);
        chk("rs_ack_data", out_path, 12'h108);
        chk("rs_ack_cnt", path_cnt, 2);
        repeat (DAY) step();
        prc_ack = 1; step(); prc_ack = 0;
        chk("p2_cnt", path_cnt, 3);

        // Full run of N paths with immediate acks.
        start = 1; step(); start = 0;
        was_last = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            gen_valid = 1; gen_path = W'(12'h200 + k);
            prc_ack = was_last;
            was_last = out_last;
            step();
        end
        prc_ack = 0;
        chk("run_done", done, 1);
        chk("run_cnt", path_cnt, N);
        chk("run_busy", busy, 0);
        chk("run_hold", gen_hold, 1);
        repeat (4) step();
        gen_valid = 0;
        chk("after_done_valid", out_valid, 0);
        chk("after_done_cnt", path_cnt, N);

        // Start mid-stream discards buffered data.
        start = 1; step(); start = 0;
        for (int i = 0; i < DAY; i++) begin
            gen_valid = 1; gen_path = W'(12'h300 + i); step();
        end
        gen_valid = 0;
        step();
        chk("s_first", out_path, 12'h300);
        repeat (3) step();
        start = 1; step(); start = 0;
        chk("mid_start_valid", out_valid, 0);
        chk("mid_start_cnt", path_cnt, 0);
        chk("mid_start_busy", busy, 1);
        chk("mid_start_hold", gen_hold, 0);

        // Async reset mid-stream.
        for (int i = 0; i < DAY; i++) begin
            gen_valid = 1; gen_path = W'(12'h400 + i); step();
        end
        gen_valid = 0;
        step();
        chk("r_first", out_path, 12'h400);
        step();
        #2 rst_n = 0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_path", out_path, 0);
        chk("arst_last", out_last, 0);
        chk("arst_cnt", path_cnt, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_hold", gen_hold, 1);
        step();
        rst_n = 1;
        step();
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_hold", gen_hold, 1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
